// File: rtl/fm_pkg.sv
// fm_pkg: shared widths and word types for the FM phase path
package fm_pkg;
    localparam int PINC_W  = 32;
    localparam int ACC_W   = 32;
    localparam int PHASE_W = 16;
    localparam int WRAP_W  = 16;
    typedef logic [PINC_W-1:0]  pinc_t;
    typedef logic [ACC_W-1:0]   acc_t;
    typedef logic [PHASE_W-1:0] phase_t;
endpackage

// File: rtl/fm_phase_accumulator_if.sv
// fm_phase_accumulator_if: AXI-Stream channel, tuser carried only on the master side
interface fm_phase_accumulator_if
    import fm_pkg::*;
#(
    parameter int DW = PINC_W
);
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic [DW-1:0] tdata;
    modport master(output tvalid, tdata, tuser, input tready);
    modport slave(input tvalid, tdata, output tready);
endinterface

// File: rtl/fm_phase_accumulator_axis_skid_buffer.sv
// fm_phase_accumulator_axis_skid_buffer: output register plus one skid entry, registered upstream ready
module fm_phase_accumulator_axis_skid_buffer #(
    parameter int DW = 17
) (
    input  logic          aclk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    logic          skid_valid, skid_valid_n, out_valid_n, accept, out_free;
    logic [DW-1:0] skid_data, skid_data_n, out_data_n;

    assign accept   = in_valid & in_ready;
    assign out_free = !out_valid | out_ready;

    // next state: a free output takes the skid entry first, else the new beat; a stalled output parks the beat in skid
    always_comb begin
        skid_valid_n = !out_free & (skid_valid | accept);
        skid_data_n  = (!out_free & accept) ? in_data : skid_data;
        out_valid_n  = out_free ? (skid_valid | accept) : 1'b1;
        out_data_n   = !out_free ? out_data : skid_valid ? skid_data : accept ? in_data : out_data;
    end

    // state registers; ready is simply "skid will be empty"
    always_ff @(posedge aclk) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            in_ready   <= 1'b0;
        end else begin
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            in_ready   <= !skid_valid_n;
        end
    end
endmodule

// File: rtl/fm_phase_accumulator.sv
// fm_phase_accumulator: integrates phase increments and emits offset, truncated phase words with wrap flag
module fm_phase_accumulator
    import fm_pkg::*;
#(
    parameter int PINC_WIDTH      = PINC_W,
    parameter int ACC_WIDTH       = ACC_W,
    parameter int PHASE_OUT_WIDTH = PHASE_W,
    parameter int WRAP_CNT_WIDTH  = WRAP_W
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic [ACC_WIDTH-1:0]      phase_offset,
    input  logic                      resync,
    fm_phase_accumulator_if.slave     S_AXIS,
    fm_phase_accumulator_if.master    M_AXIS,
    output logic [WRAP_CNT_WIDTH-1:0] wrap_count
);
    logic [ACC_WIDTH-1:0] acc, base, phase_sum;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept;

    assign accept = S_AXIS.tvalid & S_AXIS.tready;

    // a resync in the same cycle as a beat makes that beat start from zero
    always_comb begin
        base      = resync ? '0 : acc;
        sum       = {1'b0, base} + (ACC_WIDTH+1)'(S_AXIS.tdata);
        phase_sum = base + phase_offset;
    end

    // accumulator and saturating wrap counter; resync clears both
    always_ff @(posedge aclk) begin
        acc        <= reset ? '0 : accept ? sum[ACC_WIDTH-1:0] : resync ? '0 : acc;
        wrap_count <= (reset | resync) ? '0
                    : (accept & sum[ACC_WIDTH] & ~&wrap_count) ? wrap_count + WRAP_CNT_WIDTH'(1)
                    : wrap_count;
    end

    fm_phase_accumulator_axis_skid_buffer #(.DW(PHASE_OUT_WIDTH + 1)) u_skid (
        .aclk      (aclk),
        .reset     (reset),
        .in_valid  (S_AXIS.tvalid),
        .in_ready  (S_AXIS.tready),
        .in_data   ({sum[ACC_WIDTH], phase_sum[ACC_WIDTH-1 -: PHASE_OUT_WIDTH]}),
        .out_valid (M_AXIS.tvalid),
        .out_ready (M_AXIS.tready),
        .out_data  ({M_AXIS.tuser, M_AXIS.tdata})
    );
endmodule

// File: tb/tb_fm_phase_accumulator.sv
// tb_fm_phase_accumulator: directed and random stimulus against a queue-based beat model
module tb_fm_phase_accumulator;
    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        resync = 1'b0;
    logic [31:0] offset = '0;
    logic [15:0] wc;
    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic [31:0] m_acc = '0;
    int          m_wc = 0;
    bit          prev_rst = 1'b1;
    logic [16:0] q[$];
    logic [16:0] got[$];
    logic [31:0] pincs[3] = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000};

    fm_phase_accumulator_if #(.DW(32)) s_if ();
    fm_phase_accumulator_if #(.DW(16)) m_if ();

    fm_phase_accumulator dut (
        .aclk         (aclk),
        .reset        (reset),
        .phase_offset (offset),
        .resync       (resync),
        .S_AXIS       (s_if),
        .M_AXIS       (m_if),
        .wrap_count   (wc)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [32:0] s;
        logic [31:0] ps;
        @(negedge aclk);
        chk("s_tready", 32'(!prev_rst && q.size() < 2), 32'(s_if.tready));
        chk("m_tvalid", 32'(m_if.tvalid), 32'(q.size() > 0));
        chk("wrap_count", 32'(wc), 32'(m_wc));
        if (m_if.tvalid && q.size() > 0) chk("m_beat", 32'({m_if.tuser, m_if.tdata}), 32'(q[0]));
        if (reset) begin
            q.delete();
            m_acc = '0;
            m_wc = 0;
        end else begin
            if (m_if.tvalid && m_if.tready) begin
                got.push_back({m_if.tuser, m_if.tdata});
                if (q.size() > 0) void'(q.pop_front());
            end
            if (resync) begin
                m_acc = '0;
                m_wc = 0;
            end
            if (s_if.tvalid && s_if.tready) begin
                n_acc++;
                s = {1'b0, m_acc} + {1'b0, s_if.tdata};
                ps = m_acc + offset;
                q.push_back({s[32], ps[31:16]});
                m_acc = s[31:0];
                if (s[32] && m_wc < 65535) m_wc++;
            end
        end
        prev_rst = reset;
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        s_if.tvalid = 1'b0;
        resync = 1'b0;
        m_if.tready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic pulse_resync();
        s_if.tvalid = 1'b0;
        resync = 1'b1;
        cycle();
        resync = 1'b0;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        @(posedge aclk);
        #1;
        cycle();
        cycle();
        chk("rst_tdata", 32'(m_if.tdata), 32'd0);
        chk("rst_tuser", 32'(m_if.tuser), 32'd0);
        chk("rst_tready", 32'(s_if.tready), 32'd0);
        reset = 1'b0;
        cycle();
        chk("ready_after_rst", 32'(s_if.tready), 32'd1);

        got.delete();
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'h4000_0000;
        repeat (5) cycle();
        drain();
        chk("t1_n", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            chk("t1_b0", 32'(got[0]), 32'h0_0000);
            chk("t1_b1", 32'(got[1]), 32'h0_4000);
            chk("t1_b2", 32'(got[2]), 32'h0_8000);
            chk("t1_b3", 32'(got[3]), 32'h1_C000);
            chk("t1_b4", 32'(got[4]), 32'h0_0000);
        end
        chk("t1_wc", 32'(wc), 32'd1);

        pulse_resync();
        got.delete();
        offset = 32'h8000_0000;
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'h0100_0000;
        repeat (3) cycle();
        drain();
        chk("t2_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t2_b0", 32'(got[0]), 32'h0_8000);
            chk("t2_b1", 32'(got[1]), 32'h0_8100);
            chk("t2_b2", 32'(got[2]), 32'h0_8200);
        end

        offset = '0;
        pulse_resync();
        got.delete();
        n_acc = 0;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata = pincs[0];
        for (int i = 0; i < 4; i++) begin
            cycle();
            s_if.tdata = pincs[n_acc < 3 ? n_acc : 2];
        end
        chk("t3_accepted", 32'(n_acc), 32'd2);
        chk("t3_tready_low", 32'(s_if.tready), 32'd0);
        chk("t3_hold", 32'({m_if.tuser, m_if.tdata}), 32'h0_0000);
        m_if.tready = 1'b1;
        for (int i = 0; i < 10 && n_acc < 3; i++) begin
            cycle();
            s_if.tdata = pincs[n_acc < 3 ? n_acc : 2];
        end
        chk("t3_all_accepted", 32'(n_acc), 32'd3);
        drain();
        chk("t3_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t3_b0", 32'(got[0]), 32'h0_0000);
            chk("t3_b1", 32'(got[1]), 32'h0_0100);
            chk("t3_b2", 32'(got[2]), 32'h0_0300);
        end

        offset = 32'h0005_0000;
        pulse_resync();
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'h1234_0000;
        cycle();
        got.delete();
        resync = 1'b1;
        s_if.tdata = 32'h0010_0000;
        cycle();
        resync = 1'b0;
        chk("t4_wc", 32'(wc), 32'd0);
        cycle();
        drain();
        chk("t4_n", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t4_resync_beat", 32'(got[1]), 32'h0_0005);
            chk("t4_next_beat", 32'(got[2]), 32'h0_0015);
        end

        pulse_resync();
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'hFFFF_FFFF;
        repeat (32'h1_0001) cycle();
        drain();
        chk("t5_saturated", 32'(wc), 32'h0000_FFFF);

        pulse_resync();
        for (int i = 0; i < 400; i++) begin
            s_if.tvalid = $urandom_range(0, 3) != 0;
            s_if.tdata = $urandom;
            m_if.tready = $urandom_range(0, 3) != 0;
            resync = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 31) == 0) offset = $urandom;
            cycle();
        end
        drain();

        offset = 32'h0077_0000;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata = $urandom;
        for (int i = 0; i < 10 && q.size() < 2; i++) cycle();
        chk("t6_full", 32'(q.size()), 32'd2);
        s_if.tvalid = 1'b0;
        reset = 1'b1;
        cycle();
        chk("t6_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("t6_tdata", 32'(m_if.tdata), 32'd0);
        chk("t6_tready", 32'(s_if.tready), 32'd0);
        reset = 1'b0;
        cycle();
        chk("t6_ready_back", 32'(s_if.tready), 32'd1);
        got.delete();
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        cycle();
        drain();
        chk("t6_n", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("t6_first", 32'(got[0][15:0]), 32'h0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
